// File: rtl/game_controller.sv
// game_controller: turn-based game sequencer driving a compare/move datapath.
// Optional SELECT-state turn timer is enabled by defining TURN_TIMER_EN.
module game_controller #(
  parameter int CMP_LAT = 1,
  parameter int TIMEOUT = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] N,
  input  logic       sel_valid,
  input  logic [3:0] sel_tile,
  input  logic       go,
  input  logic       W,
  output logic [3:0] position_data,
  output logic       A,
  output logic       D,
  output logic       statecombo_next_turn,
  output logic [1:0] turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, SELECT = 3'd1, COMPARE = 3'd2, MOVE = 3'd3,
    WINCHK = 3'd4, PASS = 3'd5, OVER = 3'd6
  } st_t;
  localparam int CW = CMP_LAT > 1 ? $clog2(CMP_LAT + 1) : 1;
  st_t st;
  logic [2:0] n;
  logic [CW-1:0] cnt;
  logic legal;
  logic [2:0] inc;
  logic [1:0] turn_nx;
  logic expired;
  assign state = st;
  assign legal = (N >= 3'd2) && (N <= 3'd4);
  assign inc = {1'b0, turn} + 3'd1;
  assign turn_nx = (inc >= n) ? 2'd0 : inc[1:0];
`ifdef TURN_TIMER_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  assign expired = (tmr == TW'(TIMEOUT - 1));
  // Counts only while idling in SELECT, so it is zero on every SELECT entry.
  always_ff @(posedge clk or negedge rst)
    if (!rst) tmr <= '0;
    else tmr <= (st == SELECT && !sel_valid) ? tmr + 1'b1 : '0;
`else
  logic unused_timeout;
  assign expired = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      n <= '0;
      cnt <= '0;
      turn <= '0;
      winner <= '0;
      position_data <= '0;
      A <= 1'b0;
      D <= 1'b0;
      statecombo_next_turn <= 1'b0;
      game_over <= 1'b0;
    end else begin
      A <= 1'b0;
      D <= 1'b0;
      statecombo_next_turn <= 1'b0;
      case (st)
        IDLE, OVER: if (start && legal) begin
          st <= SELECT;
          turn <= '0;
          n <= N;
          game_over <= 1'b0;
        end
        SELECT: if (sel_valid) begin
          position_data <= sel_tile;
          A <= 1'b1;
          cnt <= '0;
          st <= COMPARE;
        end else if (expired) begin
          statecombo_next_turn <= 1'b1;
          turn <= turn_nx;
          st <= PASS;
        end
        COMPARE: if (cnt == CW'(CMP_LAT)) begin
          if (go) begin
            D <= 1'b1;
            st <= MOVE;
          end else begin
            statecombo_next_turn <= 1'b1;
            turn <= turn_nx;
            st <= PASS;
          end
        end else cnt <= cnt + 1'b1;
        MOVE: st <= WINCHK;
        WINCHK: if (W) begin
          winner <= turn;
          game_over <= 1'b1;
          st <= OVER;
        end else st <= SELECT;
        PASS: st <= SELECT;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: vector table plus scoreboard bench for game_controller.
module tb_game_controller;
  logic clk = 0, rst = 0, start = 0, sel_valid = 0, go = 0, W = 0;
  logic [2:0] N = 0;
  logic [3:0] sel_tile = 0;
  logic [3:0] position_data;
  logic A, D, statecombo_next_turn, game_over;
  logic [1:0] turn, winner;
  logic [2:0] state;
  int checks = 0, fails = 0;
  logic prev_strobe = 0;

  typedef struct {logic [3:0] tile; logic g; logic w; logic [1:0] et; logic [2:0] es;} vec_t;
  typedef struct {logic [3:0] tile; logic [1:0] turn; logic [2:0] st;} exp_t;
  vec_t vt[6];
  exp_t sq[$];

  game_controller #(.CMP_LAT(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N), .sel_valid(sel_valid), .sel_tile(sel_tile),
    .go(go), .W(W), .position_data(position_data), .A(A), .D(D),
    .statecombo_next_turn(statecombo_next_turn), .turn(turn), .game_over(game_over),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobes must be one-hot and never back-to-back.
  always @(negedge clk) begin
    if (rst) begin
      chk("strobe_excl", 32'(int'(A) + int'(D) + int'(statecombo_next_turn) > 1), 0);
      chk("strobe_consec", 32'(prev_strobe && (A || D || statecombo_next_turn)), 0);
    end
    prev_strobe = A || D || statecombo_next_turn;
  end

  task automatic do_start(input logic [2:0] nn);
    N = nn; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic play(input logic [3:0] tile, input logic g, input logic w,
                      input logic [1:0] et, input logic [2:0] es);
    exp_t e;
    sq.push_back('{tile, et, es});
    sel_tile = tile; sel_valid = 1;
    @(negedge clk);
    sel_valid = 0;
    chk("A_strobe", 32'(A), 1);
    chk("cmp_state", 32'(state), 2);
    go = g;
    @(negedge clk);
    chk("A_once", 32'(A), 0);
    chk("cmp_wait", 32'(state), 2);
    @(negedge clk);
    go = 0;
    if (g) begin
      chk("D_strobe", 32'(D), 1);
      chk("move_state", 32'(state), 3);
      W = w;
      @(negedge clk);
      chk("D_once", 32'(D), 0);
      chk("winchk_state", 32'(state), 4);
      @(negedge clk);
      W = 0;
    end else begin
      chk("pass_pulse", 32'(statecombo_next_turn), 1);
      chk("pass_state", 32'(state), 5);
      @(negedge clk);
      chk("pulse_once", 32'(statecombo_next_turn), 0);
    end
    e = sq.pop_front();
    chk("tile", 32'(position_data), 32'(e.tile));
    chk("turn", 32'(turn), 32'(e.turn));
    chk("state", 32'(state), 32'(e.st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt_s, cnt_a;
    vt[0] = '{4'd5,  1'b1, 1'b0, 2'd0, 3'd1};
    vt[1] = '{4'd2,  1'b0, 1'b0, 2'd1, 3'd1};
    vt[2] = '{4'd7,  1'b0, 1'b0, 2'd2, 3'd1};
    vt[3] = '{4'd9,  1'b0, 1'b0, 2'd0, 3'd1};
    vt[4] = '{4'd3,  1'b0, 1'b0, 2'd1, 3'd1};
    vt[5] = '{4'd12, 1'b1, 1'b1, 2'd1, 3'd6};
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", 32'({position_data, A, D, statecombo_next_turn, turn, game_over, winner}), 0);
    rst = 1;
    @(negedge clk);
    do_start(3'd5);
    chk("illegal_n_idle", 32'(state), 0);
    do_start(3'd3);
    chk("start_select", 32'(state), 1);
    chk("start_turn", 32'(turn), 0);
    N = 3'd2;
    for (int i = 0; i < 6; i++) play(vt[i].tile, vt[i].g, vt[i].w, vt[i].et, vt[i].es);
    chk("game_over", 32'(game_over), 1);
    chk("winner", 32'(winner), 1);
    sel_valid = 1; sel_tile = 4'd1;
    @(negedge clk);
    sel_valid = 0;
    chk("over_ignore_sel", 32'(state), 6);
    chk("over_no_A", 32'(A), 0);
    chk("over_winner_hold", 32'(winner), 1);
    do_start(3'd2);
    chk("restart_select", 32'(state), 1);
    chk("restart_turn", 32'(turn), 0);
    chk("restart_clear_over", 32'(game_over), 0);
    play(4'd6, 1'b0, 1'b0, 2'd1, 3'd1);
    play(4'd8, 1'b0, 1'b0, 2'd0, 3'd1);
    sel_valid = 1; sel_tile = 4'd11;
    @(negedge clk);
    sel_valid = 0;
    chk("pre_rst_compare", 32'(state), 2);
    rst = 0;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_outs", 32'({position_data, A, D, statecombo_next_turn, turn, game_over, winner}), 0);
    @(negedge clk);
    rst = 1;
    go = 1; W = 1;
    cnt_s = 0;
    for (int i = 0; i < 10; i++) begin
      sel_valid = (i % 3 == 0);
      @(negedge clk);
      if (A || D || statecombo_next_turn) cnt_s++;
    end
    sel_valid = 0; go = 0; W = 0;
    chk("post_rst_no_strobe", 32'(cnt_s), 0);
    chk("post_rst_idle", 32'(state), 0);
`ifdef TURN_TIMER_EN
    do_start(3'd3);
    chk("tmr_select", 32'(state), 1);
    cnt_s = 0; cnt_a = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (statecombo_next_turn) cnt_s++;
      if (A) cnt_a++;
    end
    chk("tmr_pulses", 32'(cnt_s), 1);
    chk("tmr_no_A", 32'(cnt_a), 0);
    chk("tmr_turn", 32'(turn), 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter CMP_LAT, default 1: cycles from the A strobe until go is valid.
REQ-002 Parameter TIMEOUT, default 50000000: SELECT-state idle cycles before the turn is forfeited (used only with TURN_TIMER_EN).
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: begin game, sampled in IDLE/OVER only.
REQ-006 Port N, input, 3: player count; legal values 2..4.
REQ-007 Port sel_valid, input, 1: player has chosen a tile, sampled in SELECT only.
REQ-008 Port sel_tile, input, 4: chosen tile index.
REQ-009 Port go, input, 1: datapath match result.
REQ-010 Port W, input, 1: datapath win flag.
REQ-011 Port position_data, output, 4: registered tile index driven to the datapath.
REQ-012 Port A, output, 1: one-cycle compare strobe.
REQ-013 Port D, output, 1: one-cycle move strobe.
REQ-014 Port statecombo_next_turn, output, 1: one-cycle turn-advance pulse.
REQ-015 Port turn, output, 2: current player index, 0..N-1.
REQ-016 Port game_over, output, 1: high while in OVER.
REQ-017 Port winner, output, 2: index of the winning player, valid while game_over is high.
REQ-018 Port state, output, 3: state encoding, for debug.

Function
REQ-019 The state machine SHALL have these states and encodings: IDLE=0, SELECT=1, COMPARE=2, MOVE=3, WINCHK=4, PASS=5, OVER=6.
REQ-020 IDLE: start=1 with N in 2..4 SHALL go to SELECT with turn=0; start with an illegal N SHALL leave the block in IDLE.
REQ-021 SELECT: sel_valid=1 SHALL latch sel_tile into position_data, assert A on the next cycle for exactly one cycle, and enter COMPARE.
REQ-022 COMPARE SHALL wait CMP_LAT cycles after A, then sample go: go=1 goes to MOVE, go=0 goes to PASS.
REQ-023 MOVE SHALL assert D for exactly one cycle, then enter WINCHK.
REQ-024 WINCHK SHALL sample W one cycle after D: W=1 latches winner=turn and goes to OVER; W=0 returns to SELECT with the same player, who continues the turn.
REQ-025 PASS SHALL pulse statecombo_next_turn for one cycle and set turn=(turn+1) mod N.
REQ-026 After PASS, the block SHALL return to SELECT on the following cycle.
REQ-027 turn arithmetic SHALL wrap from N-1 to 0.
REQ-028 N SHALL be captured at start; later changes to N SHALL be ignored until the next game.
REQ-029 OVER: game_over=1 and winner SHALL hold stable; start=1 SHALL go to SELECT with turn=0 and clear game_over.
REQ-030 sel_valid outside SELECT and start outside IDLE/OVER SHALL be ignored, with no state change.
REQ-031 If sel_valid and the timeout expire in the same cycle, sel_valid SHALL win.
REQ-032 A, D and statecombo_next_turn SHALL be mutually exclusive and never high for two consecutive cycles.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE.
REQ-034 rst=0 SHALL immediately clear turn, winner, position_data, A, D, statecombo_next_turn, game_over and the timer.
REQ-035 Reset asserted mid-game SHALL abort the game; no strobe SHALL be emitted after rst rises until a new start.

Configuration
REQ-036 With macro TURN_TIMER_EN defined, a counter SHALL run in SELECT and clear on entry to SELECT.
REQ-037 With TURN_TIMER_EN defined, the counter reaching TIMEOUT SHALL send the block to PASS with no A strobe.
REQ-038 Without TURN_TIMER_EN, no counter SHALL exist and SELECT SHALL wait indefinitely.

Verification
REQ-039 Reset then start with N=3, sel_tile=5, go=1, W=0 -> A one cycle after sel_valid, D one cycle after go sampled, back to SELECT with turn=0.
REQ-040 N=3, three consecutive go=0 selections -> three statecombo_next_turn pulses, turn sequence 1,2,0.
REQ-041 turn=1, go=1 then W=1 -> state=OVER, game_over=1, winner=1; later sel_valid ignored; start -> SELECT, turn=0.
REQ-042 start with N=5 -> remains IDLE; start with N=2 -> SELECT.
REQ-043 rst low during COMPARE -> state=0 and all outputs 0 in the same cycle; no A/D/pulse until the next start.
REQ-044 With TURN_TIMER_EN and TIMEOUT=8, no sel_valid for 8 cycles -> one statecombo_next_turn pulse, no A, turn increments.
